// File: rtl/gcd_pkg.sv
// Shared definitions for the round-robin GCD arbiter slice.
//   GCD_W        default operand/result width
//   GCD_N_REQ    default requester count
//   ST_*         raw state encodings, kept for code that still compares codes
//   gcd_arb_state_t  arbiter FSM state type (IDLE, RUN, RESP)
package gcd_pkg;

  localparam int unsigned GCD_W     = 9;
  localparam int unsigned GCD_N_REQ = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    RESP = ST_RESP
  } gcd_arb_state_t;

endpackage

// File: rtl/gcd_core.sv
// Subtractive GCD datapath.
//   clk, rst_n  clock, synchronous active-low reset
//   start       load a/b and begin iterating (one step per cycle)
//   a, b        operands sampled on start
//   done        one-cycle pulse on the final step; c is valid in that cycle
//   c           result, meaningful only while done is high
module gcd_core
  import gcd_pkg::*;
#(
  parameter int unsigned W = GCD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] c
);

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         active;

  // Zero operands finish immediately, so gcd(x,0)=x and gcd(0,0)=0.
  assign done = active && ((a_q == '0) || (b_q == '0) || (a_q == b_q));
  assign c    = (a_q == '0) ? b_q : a_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      active <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      active <= 1'b1;
    end else if (active) begin
      if (done) begin
        active <= 1'b0;
      end else if (a_q > b_q) begin
        a_q <= a_q - b_q;
      end else begin
        b_q <= b_q - a_q;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one gcd_core among N_REQ requesters.
//   clk, rst_n   clock, synchronous active-low reset
//   req_valid    per-requester request valid
//   req_ready    per-requester accept (one-hot or zero, IDLE only)
//   req_a/req_b  packed operands, requester i at [i*W +: W]
//   rsp_valid    result valid (RESP state)
//   rsp_ready    consumer accepts the result
//   rsp_id       index of the granted requester
//   rsp_c        GCD result
//   rsp_cycles   RUN cycle count, saturating (only with GCD_ARB_CYCLES_EN)
//   busy         high in any state other than IDLE
// Optional feature macro: GCD_ARB_CYCLES_EN
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int unsigned N_REQ = GCD_N_REQ,
  parameter int unsigned W     = GCD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [W-1:0]             rsp_c,
`ifdef GCD_ARB_CYCLES_EN
  output logic [15:0]              rsp_cycles,
`endif
  output logic                     busy
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  gcd_arb_state_t  state;
  logic [ID_W-1:0] rr;
  logic [ID_W-1:0] grant_idx;
  logic            found;
  logic            accept;
  logic [W-1:0]    grant_a;
  logic [W-1:0]    grant_b;
  logic            core_done;
  logic [W-1:0]    core_c;

  function automatic logic [ID_W-1:0] wrap_idx(input int unsigned k);
    return (k >= N_REQ) ? ID_W'(k - N_REQ) : ID_W'(k);
  endfunction

  // First valid requester at or after rr, wrapping around.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[wrap_idx(32'(rr) + i)]) begin
        found     = 1'b1;
        grant_idx = wrap_idx(32'(rr) + i);
      end
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign accept = rst_n && (state == IDLE) && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign grant_a = req_a[32'(grant_idx) * W +: W];
  assign grant_b = req_b[32'(grant_idx) * W +: W];

  gcd_core #(.W(W)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .a     (grant_a),
    .b     (grant_b),
    .done  (core_done),
    .c     (core_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr     <= '0;
      rsp_id <= '0;
      rsp_c  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state  <= RUN;
            rsp_id <= grant_idx;
            rr     <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        RUN: begin
          if (core_done) begin
            rsp_c <= core_c;
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_ARB_CYCLES_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_cycles <= '0;
    end else if (accept) begin
      rsp_cycles <= '0;
    end else if (state == RUN && rsp_cycles != 16'hFFFF) begin
      rsp_cycles <= rsp_cycles + 16'd1;
    end
  end
`endif

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
